// File: rtl/ex_stage.sv
// RV32I execute stage: ALU, branch/jump resolution, EX/MEM register and an
// optional iterative RV32M multiply/divide unit enabled by EX_RV32M_EN.
module ex_stage #(
    parameter int XLEN      = 32,
    parameter int MD_CYCLES = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] imm_EX,
    input  logic [XLEN-1:0] PC_EX,
    input  logic [XLEN-1:0] read1_EX,
    input  logic [XLEN-1:0] read2_EX,
    input  logic [4:0]      rd_EX,
    input  logic [3:0]      ALUctl_EX,
    input  logic [2:0]      RW_type_EX,
    input  logic            MemRead_EX,
    input  logic            MemtoReg_EX,
    input  logic            MemWrite_EX,
    input  logic            ALUSrc_EX,
    input  logic            RegWrite_EX,
    input  logic            lui_EX,
    input  logic            auipc_EX,
    input  logic            jal_EX,
    input  logic            jalr_EX,
    input  logic            B_type_EX,
    input  logic            beq_EX,
    input  logic            bne_EX,
    input  logic            blt_EX,
    input  logic            bge_EX,
    input  logic            bltu_EX,
    input  logic            bgeu_EX,
    input  logic            mdu_EX,
    output logic            B_JUMP,
    output logic [XLEN-1:0] jump_target,
    output logic            ex_stall,
    output logic [XLEN-1:0] alu_result_MEM,
    output logic [XLEN-1:0] wdata_MEM,
    output logic [4:0]      rd_MEM,
    output logic [2:0]      RW_type_MEM,
    output logic            MemRead_MEM,
    output logic            MemtoReg_MEM,
    output logic            MemWrite_MEM,
    output logic            RegWrite_MEM
);

    logic [XLEN-1:0] op_b, alu_out, ex_result, md_result;
    logic [4:0]      shamt;
    logic            eq, lt_s, lt_u, br_cond, md_done, md_block_jump;

    always_comb begin
        op_b  = ALUSrc_EX ? imm_EX : read2_EX;
        shamt = op_b[4:0];
        case (ALUctl_EX)
            4'b0001: alu_out = read1_EX - op_b;
            4'b0010: alu_out = read1_EX << shamt;
            4'b0011: alu_out = {31'd0, $signed(read1_EX) < $signed(op_b)};
            4'b0100: alu_out = {31'd0, read1_EX < op_b};
            4'b0101: alu_out = read1_EX ^ op_b;
            4'b0110: alu_out = read1_EX >> shamt;
            4'b0111: alu_out = $unsigned($signed(read1_EX) >>> shamt);
            4'b1000: alu_out = read1_EX | op_b;
            4'b1001: alu_out = read1_EX & op_b;
            default: alu_out = read1_EX + op_b;
        endcase
    end

    assign eq      = (read1_EX == read2_EX);
    assign lt_s    = ($signed(read1_EX) < $signed(read2_EX));
    assign lt_u    = (read1_EX < read2_EX);
    assign br_cond = (beq_EX & eq) | (bne_EX & ~eq) | (blt_EX & lt_s) | (bge_EX & ~lt_s)
                   | (bltu_EX & lt_u) | (bgeu_EX & ~lt_u);

    assign B_JUMP      = (jal_EX | jalr_EX | (B_type_EX & br_cond)) & ~ex_stall & ~md_block_jump;
    assign jump_target = jalr_EX ? ((read1_EX + imm_EX) & ~32'd1) : (PC_EX + imm_EX);

    always_comb begin
        if (jal_EX | jalr_EX) ex_result = PC_EX + 32'd4;
        else if (lui_EX)      ex_result = imm_EX;
        else if (auipc_EX)    ex_result = PC_EX + imm_EX;
        else if (md_done)     ex_result = md_result;
        else                  ex_result = alu_out;
    end

`ifdef EX_RV32M_EN
    // state   | meaning
    // MD_IDLE | waiting for an M instruction; latches operands when mdu_EX=1
    // MD_BUSY | one shift-add / restoring-subtract step per cycle
    // MD_DONE | sign-corrected result presented to EX/MEM for one edge
    typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_t;

    md_state_t       md_state;
    logic [5:0]      md_cnt;
    logic [XLEN-1:0] md_opnd, md_hi, md_lo;
    logic [2:0]      md_f3;
    logic            md_neg_q, md_neg_r, md_dz;
    logic            sa, sb, is_div;
    logic [XLEN-1:0] mag_a, mag_b, div_diff, quo, rem;
    logic [XLEN:0]   mul_sum, div_shift;
    logic            div_ge;
    logic [63:0]     prod;

    always_comb begin
        is_div = RW_type_EX[2];
        sa     = read1_EX[31] & (RW_type_EX == 3'b001 || RW_type_EX == 3'b010 ||
                                 RW_type_EX == 3'b100 || RW_type_EX == 3'b110);
        sb     = read2_EX[31] & (RW_type_EX == 3'b001 || RW_type_EX == 3'b100 ||
                                 RW_type_EX == 3'b110);
        mag_a  = sa ? -read1_EX : read1_EX;
        mag_b  = sb ? -read2_EX : read2_EX;
    end

    // Multiply: {hi,lo} is a right-shifting accumulator with the multiplier in lo.
    // Divide: hi is the partial remainder, lo shifts the dividend out and quotient in.
    assign mul_sum   = {1'b0, md_hi} + (md_lo[0] ? {1'b0, md_opnd} : 33'd0);
    assign div_shift = {md_hi, md_lo[31]};
    assign div_ge    = (div_shift >= {1'b0, md_opnd});
    assign div_diff  = div_shift[XLEN-1:0] - md_opnd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_state <= MD_IDLE;
            md_cnt   <= '0;
            md_opnd  <= '0;
            md_hi    <= '0;
            md_lo    <= '0;
            md_f3    <= '0;
            md_neg_q <= 1'b0;
            md_neg_r <= 1'b0;
            md_dz    <= 1'b0;
        end else begin
            case (md_state)
                MD_IDLE: if (mdu_EX) begin
                    md_opnd  <= is_div ? mag_b : mag_a;
                    md_lo    <= is_div ? mag_a : mag_b;
                    md_hi    <= '0;
                    md_f3    <= RW_type_EX;
                    md_neg_q <= sa ^ sb;
                    md_neg_r <= sa;
                    md_dz    <= is_div & (read2_EX == '0);
                    md_cnt   <= '0;
                    md_state <= MD_BUSY;
                end
                MD_BUSY: begin
                    if (md_f3[2]) begin
                        md_hi <= div_ge ? div_diff : div_shift[XLEN-1:0];
                        md_lo <= {md_lo[30:0], div_ge};
                    end else begin
                        {md_hi, md_lo} <= {mul_sum, md_lo[31:1]};
                    end
                    md_cnt <= md_cnt + 6'd1;
                    if (md_cnt == 6'(MD_CYCLES - 1)) md_state <= MD_DONE;
                end
                default: md_state <= MD_IDLE;
            endcase
        end
    end

    // Divide-by-zero forces all-ones; the remainder path already yields the dividend.
    always_comb begin
        prod = md_neg_q ? -{md_hi, md_lo} : {md_hi, md_lo};
        quo  = md_dz ? '1 : (md_neg_q ? -md_lo : md_lo);
        rem  = md_neg_r ? -md_hi : md_hi;
        case (md_f3)
            3'b000:                 md_result = prod[31:0];
            3'b001, 3'b010, 3'b011: md_result = prod[63:32];
            3'b100, 3'b101:         md_result = quo;
            default:                md_result = rem;
        endcase
    end

    assign md_done       = (md_state == MD_DONE) & mdu_EX;
    assign md_block_jump = mdu_EX;
    assign ex_stall      = ((md_state == MD_IDLE) & mdu_EX) | (md_state == MD_BUSY);
`else
    logic unused_mdu;
    assign unused_mdu    = mdu_EX ^ (MD_CYCLES == 32);
    assign md_done       = 1'b0;
    assign md_result     = '0;
    assign md_block_jump = 1'b0;
    assign ex_stall      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || ex_stall) begin
            alu_result_MEM <= '0;
            wdata_MEM      <= '0;
            rd_MEM         <= '0;
            RW_type_MEM    <= '0;
            MemRead_MEM    <= 1'b0;
            MemtoReg_MEM   <= 1'b0;
            MemWrite_MEM   <= 1'b0;
            RegWrite_MEM   <= 1'b0;
        end else begin
            alu_result_MEM <= ex_result;
            wdata_MEM      <= read2_EX;
            rd_MEM         <= rd_EX;
            RW_type_MEM    <= RW_type_EX;
            MemRead_MEM    <= MemRead_EX;
            MemtoReg_MEM   <= MemtoReg_EX;
            MemWrite_MEM   <= MemWrite_EX;
            RegWrite_MEM   <= RegWrite_EX;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed cases plus randomized instructions
// against an arithmetic reference model; M-extension cases run when EX_RV32M_EN is set.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imm_EX, PC_EX, read1_EX, read2_EX;
    logic [4:0]  rd_EX;
    logic [3:0]  ALUctl_EX;
    logic [2:0]  RW_type_EX;
    logic        MemRead_EX, MemtoReg_EX, MemWrite_EX, ALUSrc_EX, RegWrite_EX;
    logic        lui_EX, auipc_EX, jal_EX, jalr_EX, B_type_EX;
    logic        beq_EX, bne_EX, blt_EX, bge_EX, bltu_EX, bgeu_EX, mdu_EX;
    logic        B_JUMP, ex_stall;
    logic [31:0] jump_target, alu_result_MEM, wdata_MEM;
    logic [4:0]  rd_MEM;
    logic [2:0]  RW_type_MEM;
    logic        MemRead_MEM, MemtoReg_MEM, MemWrite_MEM, RegWrite_MEM;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk(clk), .rst_n(rst_n),
        .imm_EX(imm_EX), .PC_EX(PC_EX), .read1_EX(read1_EX), .read2_EX(read2_EX),
        .rd_EX(rd_EX), .ALUctl_EX(ALUctl_EX), .RW_type_EX(RW_type_EX),
        .MemRead_EX(MemRead_EX), .MemtoReg_EX(MemtoReg_EX), .MemWrite_EX(MemWrite_EX),
        .ALUSrc_EX(ALUSrc_EX), .RegWrite_EX(RegWrite_EX),
        .lui_EX(lui_EX), .auipc_EX(auipc_EX), .jal_EX(jal_EX), .jalr_EX(jalr_EX),
        .B_type_EX(B_type_EX), .beq_EX(beq_EX), .bne_EX(bne_EX), .blt_EX(blt_EX),
        .bge_EX(bge_EX), .bltu_EX(bltu_EX), .bgeu_EX(bgeu_EX), .mdu_EX(mdu_EX),
        .B_JUMP(B_JUMP), .jump_target(jump_target), .ex_stall(ex_stall),
        .alu_result_MEM(alu_result_MEM), .wdata_MEM(wdata_MEM), .rd_MEM(rd_MEM),
        .RW_type_MEM(RW_type_MEM), .MemRead_MEM(MemRead_MEM), .MemtoReg_MEM(MemtoReg_MEM),
        .MemWrite_MEM(MemWrite_MEM), .RegWrite_MEM(RegWrite_MEM)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] ctl, input logic [31:0] a,
                                            input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        case (ctl)
            4'd1:    return a - b;
            4'd2:    return a << sh;
            4'd3:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd4:    return (a < b) ? 32'd1 : 32'd0;
            4'd5:    return a ^ b;
            4'd6:    return a >> sh;
            4'd7:    return $unsigned($signed(a) >>> sh);
            4'd8:    return a | b;
            4'd9:    return a & b;
            default: return a + b;
        endcase
    endfunction

    function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [63:0] ea, eb, p;
        int sa, sb;
        sa = a;
        sb = b;
        ea = (f3 == 3'd1 || f3 == 3'd2) ? {{32{a[31]}}, a} : {32'd0, a};
        eb = (f3 == 3'd1) ? {{32{b[31]}}, b} : {32'd0, b};
        p  = ea * eb;
        case (f3)
            3'd0: return p[31:0];
            3'd1, 3'd2, 3'd3: return p[63:32];
            3'd4: return (b == 0) ? 32'hFFFF_FFFF :
                         (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 : sa / sb;
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a :
                         (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : sa % sb;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic clear_in();
        {imm_EX, PC_EX, read1_EX, read2_EX} = '0;
        rd_EX = '0; ALUctl_EX = '0; RW_type_EX = '0;
        {MemRead_EX, MemtoReg_EX, MemWrite_EX, ALUSrc_EX, RegWrite_EX} = '0;
        {lui_EX, auipc_EX, jal_EX, jalr_EX, B_type_EX} = '0;
        {beq_EX, bne_EX, blt_EX, bge_EX, bltu_EX, bgeu_EX, mdu_EX} = '0;
    endtask

    // Called at a negedge with inputs driven; returns at the following negedge.
    task automatic exec_check(input string tag);
        logic [31:0] opb, res, tgt;
        logic        cond, bj;
        opb  = ALUSrc_EX ? imm_EX : read2_EX;
        cond = (beq_EX && read1_EX == read2_EX) || (bne_EX && read1_EX != read2_EX) ||
               (blt_EX && $signed(read1_EX) < $signed(read2_EX)) ||
               (bge_EX && $signed(read1_EX) >= $signed(read2_EX)) ||
               (bltu_EX && read1_EX < read2_EX) || (bgeu_EX && read1_EX >= read2_EX);
        bj   = jal_EX || jalr_EX || (B_type_EX && cond);
        tgt  = jalr_EX ? ((read1_EX + imm_EX) & 32'hFFFF_FFFE) : PC_EX + imm_EX;
        if (jal_EX || jalr_EX) res = PC_EX + 4;
        else if (lui_EX)       res = imm_EX;
        else if (auipc_EX)     res = PC_EX + imm_EX;
        else                   res = ref_alu(ALUctl_EX, read1_EX, opb);
        #1;
        chk({tag, "/bjump"}, B_JUMP, bj);
        chk({tag, "/target"}, jump_target, tgt);
        chk({tag, "/stall"}, ex_stall, 0);
        @(posedge clk);
        #1;
        chk({tag, "/result"}, alu_result_MEM, res);
        chk({tag, "/wdata"}, wdata_MEM, read2_EX);
        chk({tag, "/rd_rw"}, {rd_MEM, RW_type_MEM}, {rd_EX, RW_type_EX});
        chk({tag, "/ctrl"}, {MemRead_MEM, MemtoReg_MEM, MemWrite_MEM, RegWrite_MEM},
            {MemRead_EX, MemtoReg_EX, MemWrite_EX, RegWrite_EX});
        @(negedge clk);
    endtask

    task automatic rand_instr();
        int cls;
        logic [5:0] kind;
        clear_in();
        imm_EX = $urandom; PC_EX = $urandom & 32'hFFFF_FFFC;
        read1_EX = $urandom; read2_EX = $urandom;
        if ($urandom_range(0, 3) == 0) read2_EX = read1_EX;
        rd_EX = 5'($urandom); ALUctl_EX = 4'($urandom); RW_type_EX = 3'($urandom);
        {MemRead_EX, MemtoReg_EX, MemWrite_EX, ALUSrc_EX, RegWrite_EX} = 5'($urandom);
        cls = $urandom_range(0, 5);
        case (cls)
            1: begin
                B_type_EX = 1'b1;
                kind = 6'b1 << $urandom_range(0, 5);
                {beq_EX, bne_EX, blt_EX, bge_EX, bltu_EX, bgeu_EX} = kind;
            end
            2: jal_EX = 1'b1;
            3: jalr_EX = 1'b1;
            4: lui_EX = 1'b1;
            5: auipc_EX = 1'b1;
            default: ;
        endcase
    endtask

`ifdef EX_RV32M_EN
    task automatic md_check(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp);
        int n;
        clear_in();
        mdu_EX = 1'b1; RW_type_EX = f3; read1_EX = a; read2_EX = b;
        RegWrite_EX = 1'b1; rd_EX = 5'd7;
        n = 0;
        #1;
        while (ex_stall === 1'b1 && n < 100) begin
            n++;
            if (B_JUMP !== 1'b0) chk({tag, "/bjump_stall"}, B_JUMP, 0);
            @(posedge clk);
            #1;
            if (RegWrite_MEM !== 1'b0) chk({tag, "/bubble"}, RegWrite_MEM, 0);
            @(negedge clk);
            #1;
        end
        chk({tag, "/stall_cycles"}, n, 33);
        chk({tag, "/bjump_done"}, B_JUMP, 0);
        @(posedge clk);
        #1;
        chk({tag, "/result"}, alu_result_MEM, exp);
        chk({tag, "/regwrite"}, {RegWrite_MEM, rd_MEM}, {1'b1, 5'd7});
        @(negedge clk);
        mdu_EX = 1'b0;
    endtask
`endif

    initial begin
        clear_in();
        rst_n = 1'b0;
        #1;
        chk("reset/outputs", {alu_result_MEM, wdata_MEM, rd_MEM, RW_type_MEM, RegWrite_MEM}, 0);
        chk("reset/stall", ex_stall, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        clear_in(); read1_EX = 32'd5; read2_EX = 32'hFFFF_FFFD; RegWrite_EX = 1'b1; rd_EX = 5'd3;
        #1;
        chk("add/bjump", B_JUMP, 0);
        @(posedge clk);
        #1;
        chk("add/result", alu_result_MEM, 32'd2);
        @(negedge clk);

        clear_in(); read1_EX = 32'hFFFF_FFFF; read2_EX = 32'd1; PC_EX = 32'h100; imm_EX = 32'h20;
        B_type_EX = 1'b1; blt_EX = 1'b1;
        #1;
        chk("blt/bjump", B_JUMP, 1);
        chk("blt/target", jump_target, 32'h120);
        blt_EX = 1'b0; bltu_EX = 1'b1;
        #1;
        chk("bltu/bjump", B_JUMP, 0);
        @(negedge clk);

        clear_in(); PC_EX = 32'h40; read1_EX = 32'h1001; imm_EX = 32'd2; jalr_EX = 1'b1;
        #1;
        chk("jalr/target", jump_target, 32'h1002);
        @(posedge clk);
        #1;
        chk("jalr/result", alu_result_MEM, 32'h44);
        @(negedge clk);

        for (int i = 0; i < 300; i++) begin
            rand_instr();
            exec_check("rand");
        end

        clear_in(); lui_EX = 1'b1; imm_EX = 32'h1234_5000; RegWrite_EX = 1'b1; read2_EX = 32'h55;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset/result", alu_result_MEM, 0);
        chk("async_reset/ctrl", {RegWrite_MEM, wdata_MEM}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

`ifdef EX_RV32M_EN
        md_check("mulh", 3'd1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF);
        md_check("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        md_check("divu_zero", 3'd5, 32'd7, 32'd0, 32'hFFFF_FFFF);
        md_check("rem_zero", 3'd6, 32'd7, 32'd0, 32'd7);
        md_check("div_neg_zero", 3'd4, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF);
        md_check("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        for (int i = 0; i < 24; i++) begin
            logic [2:0]  f3;
            logic [31:0] a, b;
            f3 = 3'($urandom);
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31);
            md_check("md_rand", f3, a, b, ref_md(f3, a, b));
        end

        clear_in(); mdu_EX = 1'b1; RW_type_EX = 3'd0; read1_EX = 32'd9; read2_EX = 32'd9;
        RegWrite_EX = 1'b1;
        for (int i = 0; i < 11; i++) @(negedge clk);
        #1;
        chk("busy/stall_before_reset", ex_stall, 1);
        rst_n = 1'b0;
        #1;
        chk("busy_reset/stall", ex_stall, 0);
        chk("busy_reset/outputs", {alu_result_MEM, RegWrite_MEM, rd_MEM, B_JUMP}, 0);
        @(negedge clk);
        mdu_EX = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        clear_in(); read1_EX = 32'd5; read2_EX = 32'hFFFF_FFFD; RegWrite_EX = 1'b1; rd_EX = 5'd4;
        exec_check("post_reset_add");
`else
        clear_in(); mdu_EX = 1'b1; RW_type_EX = 3'd4; read1_EX = 32'd40; read2_EX = 32'd2;
        ALUctl_EX = 4'd1; RegWrite_EX = 1'b1;
        exec_check("mdu_ignored");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the RV32I 5-stage pipeline, directly downstream of the ID/EX register.
- Consumes ID/EX control and operands, computes the ALU/U-type/link result and resolves branches and jumps.
- Drives B_JUMP and the redirect target back to IF and the ID/EX flush, and holds the EX/MEM pipeline register.
- Contains an iterative RV32M multiply/divide engine that stalls the front end while busy.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- MD_CYCLES, 32, iterations per multiply/divide operation; must equal XLEN.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- imm_EX, PC_EX, read1_EX, read2_EX  in  32 each  operands from ID/EX
- rd_EX  in  5  destination register
- ALUctl_EX  in  4  ALU operation
- RW_type_EX  in  3  funct3 of the instruction
- MemRead_EX, MemtoReg_EX, MemWrite_EX, ALUSrc_EX, RegWrite_EX  in  1 each  control
- lui_EX, auipc_EX, jal_EX, jalr_EX, B_type_EX  in  1 each  instruction class
- beq_EX, bne_EX, blt_EX, bge_EX, bltu_EX, bgeu_EX  in  1 each  branch kind
- mdu_EX  in  1  instruction is RV32M; RW_type_EX selects the op
- B_JUMP  out  1  combinational redirect/flush request
- jump_target  out  32  combinational redirect PC
- ex_stall  out  1  combinational; freezes PC, IF/ID and ID/EX
- alu_result_MEM, wdata_MEM  out  32 each  registered result and store data
- rd_MEM  out  5  registered
- RW_type_MEM  out  3  registered
- MemRead_MEM, MemtoReg_MEM, MemWrite_MEM, RegWrite_MEM  out  1 each  registered

Behaviour:
- Reset (async): every registered output is 0, the MDU FSM is IDLE, the counter is 0.
- Operand B is imm_EX when ALUSrc_EX=1, otherwise read2_EX.
- ALUctl_EX encoding:
  - 0000 ADD, 0001 SUB, 0010 SLL, 0011 SLT, 0100 SLTU, 0101 XOR, 0110 SRL, 0111 SRA, 1000 OR, 1001 AND.
  - 1010-1111 behave as ADD.
  - Shift amount is B[4:0].
- Result priority:
  - jal or jalr: PC_EX+4.
  - lui: imm_EX.
  - auipc: PC_EX+imm_EX.
  - MDU result when a completed mdu_EX op is in DONE.
  - Otherwise the ALU result.
  - All arithmetic is modulo 2^32.
- Branch conditions: beq eq, bne ne, blt signed lt, bge signed ge, bltu unsigned lt, bgeu unsigned ge; each compares read1_EX against read2_EX.
- B_JUMP = jal | jalr | (B_type_EX & cond).
- Target: jalr gives (read1_EX+imm_EX) & ~1; all other cases give PC_EX+imm_EX.
- B_JUMP is forced to 0 while ex_stall=1.
- EX/MEM register, captured on every clk edge:
  - When ex_stall=0: captures the result, wdata_MEM=read2_EX, rd, RW_type and the four control bits.
  - When ex_stall=1: loads a bubble (all control 0, rd 0, data 0).
  - The register has no flush input; the instruction that raised B_JUMP itself proceeds to MEM.
- MDU FSM, states IDLE, BUSY, DONE:
  - IDLE: when mdu_EX=1, latch operand magnitudes and sign info, clear the counter, go to BUSY.
  - BUSY: one shift-add (multiply) or restoring-subtract (divide) step per cycle. After MD_CYCLES steps go to DONE.
  - DONE: apply result sign, present the result, return to IDLE on the next edge.
- ex_stall = (IDLE & mdu_EX) | BUSY.
- Total EX occupancy of an M instruction is 1+MD_CYCLES+1 = 34 cycles. The result enters EX/MEM at the DONE edge.
- ID/EX contents are held stable by the upstream stall while the MDU runs; the FSM does not re-sample operands after IDLE.
- RW_type_EX ops:
  - MUL returns the low word.
  - MULH, MULHSU, MULHU return the high word with signed×signed, signed×unsigned and unsigned×unsigned operands.
  - DIV, DIVU, REM, REMU.
- Divide by zero: quotient 0xFFFFFFFF, remainder = dividend. This applies to signed and unsigned ops, with the same latency.
- Signed overflow 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
- An mdu_EX op never asserts B_JUMP.
- Reset during BUSY aborts the operation immediately: state IDLE, ex_stall=0, nothing is written.

Optional Feature:
- Macro EX_RV32M_EN.
- Defined: the MDU and FSM are present as specified above.
- Undefined: there is no MDU logic, mdu_EX is ignored (the instruction executes through the ALU path), ex_stall is tied to 0, and every instruction has single-cycle EX latency.

Test Plan:
- ADD: read1=5, read2=0xFFFFFFFD, ALUctl=0000, ALUSrc=0 -> alu_result_MEM=2 one edge later, B_JUMP=0.
- blt: read1=0xFFFFFFFF, read2=1, PC=0x100, imm=0x20 -> B_JUMP=1 and jump_target=0x120 in the same cycle. With bltu and the same operands -> B_JUMP=0.
- jalr: PC=0x40, read1=0x1001, imm=2 -> jump_target=0x1002, alu_result_MEM=0x44.
- MUL with EX_RV32M_EN defined: MULH of 0xFFFFFFFE × 3 -> ex_stall high for 33 cycles, then alu_result_MEM=0xFFFFFFFF. EX/MEM holds bubbles (RegWrite_MEM=0) during the stall.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. DIVU 7/0 -> 0xFFFFFFFF. REM 7/0 -> 7.
- rst_n low at BUSY cycle 10 -> ex_stall=0 and all outputs 0 immediately. After release, a new ADD completes normally.
